// File: rtl/probe_pkg.sv
// Shared types and helpers for the probe scan display: step FSM states and
// the hex-to-seven-segment glyph table (segments active-low, {dp,g,f,e,d,c,b,a}).
package probe_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        PRESSED,
        WAIT_RELEASE
    } step_state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Returns the active-low glyph with the decimal point off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] lit;
        case (nib)
            4'h0: lit = 7'h3F;
            4'h1: lit = 7'h06;
            4'h2: lit = 7'h5B;
            4'h3: lit = 7'h4F;
            4'h4: lit = 7'h66;
            4'h5: lit = 7'h6D;
            4'h6: lit = 7'h7D;
            4'h7: lit = 7'h07;
            4'h8: lit = 7'h7F;
            4'h9: lit = 7'h6F;
            4'hA: lit = 7'h77;
            4'hB: lit = 7'h7C;
            4'hC: lit = 7'h39;
            4'hD: lit = 7'h5E;
            4'hE: lit = 7'h79;
            default: lit = 7'h71;
        endcase
        return {1'b1, ~lit};
    endfunction

endpackage

// File: rtl/step_debouncer.sv
// Synchronises and debounces the raw step push-button; emits a one-cycle
// step pulse per accepted press, re-arming only after a debounced release.
module step_debouncer
    import probe_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic step_btn,
    output logic step
);
    localparam int unsigned CW = $clog2(DB_CYCLES);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt;
    step_state_t   state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            cnt    <= '0;
            state  <= IDLE;
            step   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], step_btn};
            step   <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync_q[1]) begin
                        cnt   <= '0;
                        state <= WAIT_PRESS;
                    end
                end
                WAIT_PRESS: begin
                    if (!sync_q[1]) begin
                        state <= IDLE;
                    end else if (cnt == CW'(DB_CYCLES - 1)) begin
                        state <= PRESSED;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PRESSED: begin
                    step  <= 1'b1;
                    cnt   <= '0;
                    state <= WAIT_RELEASE;
                end
                default: begin
                    // Any bounce back to 1 restarts the release window.
                    if (sync_q[1]) begin
                        cnt <= '0;
                    end else if (cnt == CW'(DB_CYCLES - 1)) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/probe_scan_display.sv
// Probe channel capture, multiplexed seven-segment scan and CPU clock-enable.
// Define PROBE_LZ_BLANK_EN to blank leading zero digits above the top non-zero nibble.
module probe_scan_display
    import probe_pkg::*;
#(
    parameter int unsigned CH          = 4,
    parameter int unsigned DW          = 32,
    parameter int unsigned DIGITS      = 8,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DB_CYCLES   = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CH*DW-1:0]      probe_data,
    input  logic [$clog2(CH)-1:0] sel,
    input  logic                  freeze,
    input  logic                  run_mode,
    input  logic                  step_btn,
    output logic                  cpu_ce,
    output logic [DW-1:0]         shown,
    output logic [CH-1:0]         led_ch,
    output logic [DIGITS-1:0]     AN,
    output logic [7:0]            seg
);
    localparam int unsigned NIB   = DW / 4;
    localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DW-1:0]     pick_c;
    logic [CH-1:0]     onehot_c;
    logic [DIV_W-1:0]  div_cnt;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        nib_c;
    logic              vis_c;
    logic [DIGITS-1:0] an_c;
    logic [7:0]        seg_c;
    logic              step;

    // Channel mux; an out-of-range select yields zero data and no LED.
    always_comb begin
        pick_c   = '0;
        onehot_c = '0;
        for (int k = 0; k < int'(CH); k++) begin
            if (int'(sel) == k) begin
                pick_c      = probe_data[k*DW +: DW];
                onehot_c[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shown  <= '0;
            led_ch <= '0;
        end else if (!freeze) begin
            shown  <= pick_c;
            led_ch <= onehot_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (div_cnt == DIV_W'(REFRESH_DIV - 1)) begin
            div_cnt <= '0;
            idx     <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

`ifdef PROBE_LZ_BLANK_EN
    int lead_c;

    // Position of the most significant non-zero nibble; 0 keeps digit 0 lit.
    always_comb begin
        lead_c = 0;
        for (int i = 0; i < int'(NIB); i++) begin
            if (shown[i*4 +: 4] != 4'h0) lead_c = i;
        end
    end
`endif

    always_comb begin
        nib_c = 4'h0;
        vis_c = 1'b0;
        an_c  = '1;
        seg_c = SEG_BLANK;
        for (int i = 0; i < int'(NIB); i++) begin
            if (int'(idx) == i) begin
                nib_c = shown[i*4 +: 4];
                vis_c = 1'b1;
            end
        end
`ifdef PROBE_LZ_BLANK_EN
        if (int'(idx) > lead_c) vis_c = 1'b0;
`endif
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (vis_c && int'(idx) == d) an_c[d] = 1'b0;
        end
        if (vis_c) begin
            seg_c = hex_to_seg(nib_c);
            if (idx == '0 && freeze) seg_c[7] = 1'b0;
        end
    end

    // Digit enable and segments share one register stage so they change together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            AN  <= '1;
            seg <= SEG_BLANK;
        end else begin
            AN  <= an_c;
            seg <= seg_c;
        end
    end

    step_debouncer #(
        .DB_CYCLES(DB_CYCLES)
    ) u_step (
        .clk     (clk),
        .reset   (reset),
        .step_btn(step_btn),
        .step    (step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_ce <= 1'b0;
        end else begin
            cpu_ce <= run_mode ? 1'b1 : step;
        end
    end

endmodule

// File: tb/tb_probe_scan_display.sv
// Directed bench for probe_scan_display: a 4x32-bit instance plus a 2x16-bit
// instance for digit blanking (expectations follow PROBE_LZ_BLANK_EN).
module tb_probe_scan_display;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] probe = '0;
    logic [1:0]   sel = '0;
    logic         freeze = 1'b0;
    logic         run_mode = 1'b0;
    logic         step_btn = 1'b0;
    logic         cpu_ce;
    logic [31:0]  shown;
    logic [3:0]   led_ch;
    logic [7:0]   an;
    logic [7:0]   seg;

    logic [31:0]  probe2 = 32'h0000_00A0;
    logic         sel2 = 1'b0;
    logic         cpu_ce2;
    logic [15:0]  shown2;
    logic [1:0]   led2;
    logic [7:0]   an2;
    logic [7:0]   seg2;

    int total = 0;
    int bad = 0;
    int ce_hi = 0;
    int ce_run = 0;
    int ce_max = 0;

    always #5 clk = ~clk;

    probe_scan_display #(
        .CH(4), .DW(32), .DIGITS(8), .REFRESH_DIV(4), .DB_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset), .probe_data(probe), .sel(sel), .freeze(freeze),
        .run_mode(run_mode), .step_btn(step_btn), .cpu_ce(cpu_ce), .shown(shown),
        .led_ch(led_ch), .AN(an), .seg(seg)
    );

    probe_scan_display #(
        .CH(2), .DW(16), .DIGITS(8), .REFRESH_DIV(4), .DB_CYCLES(8)
    ) dut16 (
        .clk(clk), .reset(reset), .probe_data(probe2), .sel(sel2), .freeze(1'b0),
        .run_mode(1'b0), .step_btn(1'b0), .cpu_ce(cpu_ce2), .shown(shown2),
        .led_ch(led2), .AN(an2), .seg(seg2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n clocks, sampling 1 time unit after each edge and tracking cpu_ce.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (cpu_ce === 1'b1) begin
                ce_hi++;
                ce_run++;
                if (ce_run > ce_max) ce_max = ce_run;
            end else begin
                ce_run = 0;
            end
        end
    endtask

    task automatic wait_an(input logic [7:0] target);
        for (int i = 0; i < 40 && an !== target; i++) cyc(1);
    endtask

    task automatic clr_ce();
        ce_hi  = 0;
        ce_run = 0;
        ce_max = 0;
    endtask

    initial begin
        logic [7:0] exp_an;
        logic [7:0] prev;
        logic [7:0] lit;
        int         d0;

        cyc(3);
        chk("rst_shown", shown, 32'h0);
        chk("rst_led", led_ch, 4'h0);
        chk("rst_ce", cpu_ce, 1'b0);
        chk("rst_an", an, 8'hFF);
        chk("rst_seg", seg, 8'hFF);
        @(negedge clk);
        reset = 1'b0;
        cyc(2);

        // Capture with one cycle latency
        probe[64 +: 32] = 32'h1234_ABCD;
        sel = 2'd2;
        chk("cap_before_edge", shown, 32'h0);
        cyc(1);
        chk("cap_shown", shown, 32'h1234_ABCD);
        chk("cap_led", led_ch, 4'b0100);
        cyc(1);
        wait_an(8'hFE);
        chk("dig0_an", an, 8'hFE);
        chk("dig0_seg_D", seg, 8'hA1);
        wait_an(8'hFD);
        chk("dig1_seg_C", seg, 8'hC6);
        wait_an(8'h7F);
        chk("dig7_seg_1", seg, 8'hF9);

        // Freeze holds the value and lights dp on digit 0
        freeze = 1'b1;
        cyc(1);
        probe[64 +: 32] = 32'h0;
        probe[0 +: 32]  = 32'h89AB_CDEF;
        sel = 2'd0;
        cyc(3);
        chk("frz_shown", shown, 32'h1234_ABCD);
        chk("frz_led", led_ch, 4'b0100);
        wait_an(8'hFE);
        chk("frz_dp_seg", seg, 8'h21);
        freeze = 1'b0;
        cyc(1);
        chk("unfrz_shown", shown, 32'h89AB_CDEF);
        chk("unfrz_led", led_ch, 4'b0001);

        // Scan walk: each digit held exactly 4 cycles, wrapping 7 -> 0
        prev = an;
        for (int i = 0; i < 8 && an === prev; i++) cyc(1);
        chk("scan_sync", (an !== prev), 1'b1);
        d0 = 0;
        for (int d = 0; d < 8; d++) if (an[d] === 1'b0) d0 = d;
        for (int k = 0; k < 36; k++) begin
            exp_an = ~(8'(1) << ((d0 + k / 4) % 8));
            chk("scan_an", an, exp_an);
            cyc(1);
        end

        // 16-bit instance: upper four digit slots stay dark
        lit = '0;
        for (int k = 0; k < 32; k++) begin
            chk("dw16_blank", an2[7:4], 4'hF);
            lit = lit | ~an2;
            cyc(1);
        end
`ifdef PROBE_LZ_BLANK_EN
        chk("dw16_lit", lit, 8'h03);
`else
        chk("dw16_lit", lit, 8'h0F);
`endif
        chk("dw16_shown", shown2, 16'h00A0);
        chk("dw16_led", led2, 2'b01);
        chk("dw16_ce", cpu_ce2, 1'b0);
        for (int i = 0; i < 40 && an2 !== 8'hFD; i++) cyc(1);
        chk("dw16_dig1_A", seg2, 8'h88);
        for (int i = 0; i < 40 && an2 !== 8'hFE; i++) cyc(1);
        chk("dw16_dig0_0", seg2, 8'hC0);

        // Single-step with bounce on press and release
        run_mode = 1'b0;
        clr_ce();
        for (int i = 0; i < 20; i++) begin
            step_btn = ((i / 3) % 2) == 0;
            cyc(1);
        end
        chk("bounce_only", ce_hi, 0);
        step_btn = 1'b1;
        cyc(12);
        for (int i = 0; i < 12; i++) begin
            step_btn = ((i / 3) % 2) == 1;
            cyc(1);
        end
        step_btn = 1'b0;
        cyc(16);
        chk("step1_count", ce_hi, 1);
        chk("step1_width", ce_max, 1);
        step_btn = 1'b1;
        cyc(14);
        step_btn = 1'b0;
        cyc(16);
        chk("step2_count", ce_hi, 2);
        chk("step2_width", ce_max, 1);

        // Free-run; a press accepted during run is consumed
        run_mode = 1'b1;
        cyc(1);
        chk("run_ce", cpu_ce, 1'b1);
        clr_ce();
        step_btn = 1'b1;
        cyc(14);
        step_btn = 1'b0;
        cyc(16);
        chk("run_const", ce_hi, 30);
        run_mode = 1'b0;
        cyc(1);
        chk("run_fall", cpu_ce, 1'b0);
        clr_ce();
        cyc(10);
        chk("run_consumed", ce_hi, 0);

        // Asynchronous reset in the middle of a press
        step_btn = 1'b1;
        cyc(5);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_ce", cpu_ce, 1'b0);
        chk("arst_an", an, 8'hFF);
        chk("arst_shown", shown, 32'h0);
        chk("arst_seg", seg, 8'hFF);
        step_btn = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        clr_ce();
        cyc(20);
        chk("arst_step_lost", ce_hi, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
